// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the CPU-side BRAM controller:
// sizes, FSM and read-source encodings, and the address region decoder.
package mem_map_pkg;

    localparam int DW        = 16;
    localparam int AW        = 15;
    localparam int MEM_WORDS = 24576;
    localparam int KBD_ADDR  = 24576;

    // Address constants at bus width so comparisons stay width-matched
    localparam logic [AW-1:0] LAST_WORD_A = AW'(MEM_WORDS - 1);
    localparam logic [AW-1:0] KBD_ADDR_A  = AW'(KBD_ADDR);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_BRAM = 2'd0,
        SRC_KBD  = 2'd1,
        SRC_ZERO = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        RGN_MEM      = 2'd0,
        RGN_KBD      = 2'd1,
        RGN_UNMAPPED = 2'd2
    } region_t;

    // Classify a bus address: BRAM words, the keyboard register, or nothing
    function automatic region_t addr_decode(input logic [AW-1:0] addr);
        region_t rgn;
        if (addr <= LAST_WORD_A) begin
            rgn = RGN_MEM;
        end else if (addr == KBD_ADDR_A) begin
            rgn = RGN_KBD;
        end else begin
            rgn = RGN_UNMAPPED;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Zero-fill sequencer: sweeps every BRAM word once, emitting one write
// strobe per cycle, then raises a sticky done flag. Restartable through
// i_start so the same block can later drive a screen clear.
module mem_clear_seq
    import mem_map_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic          o_last,
    output logic          o_done
);

    logic          r_active;
    logic [AW-1:0] r_cnt;
    logic          r_done;

    // Sweep counter: runs from reset (or i_start) until the last word is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else if (r_active) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_WORD_A) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    // Terminal compare is against the last BRAM word, never the keyboard slot
    assign o_we   = r_active;
    assign o_addr = r_cnt;
    assign o_last = r_active && (r_cnt == LAST_WORD_A);
    assign o_done = r_done;

endmodule

// File: rtl/mem_ctrl.sv
// CPU-to-BRAM bus controller. Zero-fills the BRAM after reset, then turns
// CPU requests into BRAM port strobes, maps the keyboard register just past
// the end of memory, and flags accesses beyond it.
module mem_ctrl
    import mem_map_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic          addr_err,
    output logic          init_done,
    input  logic [DW-1:0] kbd_code,
    output logic [DW-1:0] bram_in,
    input  logic [DW-1:0] bram_out,
    output logic [AW-1:0] bram_addr_r,
    output logic [AW-1:0] bram_addr_w,
    output logic          b_ce_w,
    output logic          b_ce_r
);

    state_t        r_state;
    src_t          r_src;
    logic [DW-1:0] r_kbd;
    logic [DW-1:0] r_rdata;
    logic          r_rvalid;
    logic          r_addr_err;

    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_clr_last;
    logic          w_clr_done;
    region_t       w_region;
    logic          w_idle;
    logic          w_clearing;

    mem_clear_seq u_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (1'b0),
        .o_we    (w_clr_we),
        .o_addr  (w_clr_addr),
        .o_last  (w_clr_last),
        .o_done  (w_clr_done)
    );

    assign w_region   = addr_decode(cpu_addr);
    assign w_idle     = (r_state == IDLE);
    assign w_clearing = (r_state == CLEAR);

    // Main FSM plus the registered read-return and error-pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_src      <= SRC_ZERO;
            r_kbd      <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rvalid   <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                CLEAR: begin
                    if (w_clr_last) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if ((cpu_we || cpu_re) && (w_region == RGN_UNMAPPED)) begin
                        r_addr_err <= 1'b1;
                    end
                    if (cpu_re) begin
                        r_state <= RD_WAIT;
                        case (w_region)
                            RGN_MEM: r_src <= SRC_BRAM;
                            RGN_KBD: begin
                                r_src <= SRC_KBD;
                                r_kbd <= kbd_code;
                            end
                            default: r_src <= SRC_ZERO;
                        endcase
                    end
                end
                RD_WAIT: begin
                    case (r_src)
                        SRC_BRAM: r_rdata <= bram_out;
                        SRC_KBD:  r_rdata <= r_kbd;
                        default:  r_rdata <= '0;
                    endcase
                    r_rvalid <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    // BRAM ports follow the CPU bus directly in IDLE; the sweep owns the
    // write port while clearing. Read and write share cpu_addr, so a
    // simultaneous read/write relies on the BRAM's read-before-write order.
    assign cpu_ready   = w_idle;
    assign bram_addr_r = cpu_addr;
    assign bram_addr_w = w_clearing ? w_clr_addr : cpu_addr;
    assign bram_in     = w_clearing ? '0 : cpu_wdata;
    assign b_ce_w      = w_clearing ? w_clr_we
                                    : (w_idle && cpu_we && (w_region == RGN_MEM));
    assign b_ce_r      = w_idle && cpu_re && (w_region == RGN_MEM);

    assign cpu_rdata  = r_rdata;
    assign cpu_rvalid = r_rvalid;
    assign addr_err   = r_addr_err;
    assign init_done  = w_clr_done;

endmodule
